// File: rtl/rom_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// rom_fetch_arbiter
//   Shares one byte-wide asynchronous program ROM between the CPU
//   instruction-fetch port (I) and the data-load port (D). Grants alternate
//   between the ports when both ask at once. Only one transaction is in flight
//   at a time. Each transaction reads 1, 2 or 4 bytes, one per cycle, and
//   returns them as a little-endian, zero-extended 32-bit word.
//
//   Handshakes: a request or response transfers on a cycle where valid and
//   ready are both high. The response stays valid, with stable data, until
//   the requester raises rsp_ready.
//
// Ports
//   clk, resetn               clock (rising edge), async active-low reset
//   i_req_valid/ready, i_addr instruction request (always 4 bytes)
//   i_rsp_valid/ready/data    instruction response
//   d_req_valid/ready, d_addr data request
//   d_size                    0=byte, 1=half, 2/3=word
//   d_rsp_valid/ready/data    data response (zero-extended)
//   rom_addr, rom_data        ROM byte address out, combinational byte in
//   busy                      high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module rom_fetch_arbiter #(
   parameter int ADDRESS_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     i_req_valid,
   output logic                     i_req_ready,
   input  logic [ADDRESS_WIDTH-1:0] i_addr,
   output logic                     i_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [31:0]              i_rsp_data,
   input  logic                     d_req_valid,
   output logic                     d_req_ready,
   input  logic [ADDRESS_WIDTH-1:0] d_addr,
   input  logic [1:0]               d_size,
   output logic                     d_rsp_valid,
   input  logic                     d_rsp_ready,
   output logic [31:0]              d_rsp_data,
   output logic [ADDRESS_WIDTH-1:0] rom_addr,
   input  logic [7:0]               rom_data,
   output logic                     busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic                     last_d_q, last_d_d;   // 1: D was granted last
   logic                     port_d_q, port_d_d;   // 1: transaction belongs to D
   logic [ADDRESS_WIDTH-1:0] base_q, base_d;
   logic [1:0]               last_k_q, last_k_d;   // index of final byte (N-1)
   logic [1:0]               k_q, k_d;             // byte index within READ
   logic [31:0]              asm_q, asm_d;         // assembly register

   logic grant_is_d;
   logic acc_i;
   logic acc_d;

   // On contention the port that was not served last wins.
   assign grant_is_d = (i_req_valid && d_req_valid) ? ~last_d_q : d_req_valid;

   // Gated by resetn so both readies are 0 while reset is asserted, even if a
   // requester is already holding valid high.
   assign acc_i = resetn && (state_q == S_IDLE) && i_req_valid && !grant_is_d;
   assign acc_d = resetn && (state_q == S_IDLE) && d_req_valid &&  grant_is_d;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         last_d_q <= 1'b1;
         port_d_q <= 1'b0;
         base_q   <= '0;
         last_k_q <= 2'd0;
         k_q      <= 2'd0;
         asm_q    <= 32'd0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         port_d_q <= port_d_d;
         base_q   <= base_d;
         last_k_q <= last_k_d;
         k_q      <= k_d;
         asm_q    <= asm_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      port_d_d = port_d_q;
      base_d   = base_q;
      last_k_d = last_k_q;
      k_d      = k_q;
      asm_d    = asm_q;
      case (state_q)
         S_IDLE: begin
            if (acc_i || acc_d) begin
               state_d  = S_READ;
               port_d_d = acc_d;
               last_d_d = acc_d;
               base_d   = acc_d ? d_addr : i_addr;
               k_d      = 2'd0;
               asm_d    = 32'd0;
               if (acc_d) begin
                  case (d_size)
                     2'd0:    last_k_d = 2'd0;
                     2'd1:    last_k_d = 2'd1;
                     default: last_k_d = 2'd3;
                  endcase
               end else begin
                  last_k_d = 2'd3;
               end
            end
         end
         S_READ: begin
            case (k_q)
               2'd0:    asm_d[7:0]   = rom_data;
               2'd1:    asm_d[15:8]  = rom_data;
               2'd2:    asm_d[23:16] = rom_data;
               default: asm_d[31:24] = rom_data;
            endcase
            if (k_q == last_k_q) begin
               state_d = S_RESP;
               k_d     = 2'd0;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         S_RESP: begin
            if (port_d_q ? d_rsp_ready : i_rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      i_req_ready = acc_i;
      d_req_ready = acc_d;
      busy        = (state_q != S_IDLE);
      i_rsp_valid = (state_q == S_RESP) && !port_d_q;
      d_rsp_valid = (state_q == S_RESP) &&  port_d_q;
      i_rsp_data  = i_rsp_valid ? asm_q : 32'd0;
      d_rsp_data  = d_rsp_valid ? asm_q : 32'd0;
      // Address arithmetic wraps naturally at 2^ADDRESS_WIDTH.
      rom_addr    = (state_q == S_READ) ? (base_q + ADDRESS_WIDTH'(k_q)) : '0;
   end

endmodule
